// File: rtl/ram_copy_engine_pkg.sv
// Shared widths and FSM encodings for the RAM16K copy/fill engine.
`timescale 1ns/1ps
package ram_copy_engine_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/ram_addr_counter.sv
// Loadable address up-counter; wraps naturally modulo 2**ADDR_W.
`timescale 1ns/1ps
module ram_addr_counter #(
  parameter int ADDR_W = 14
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr
);
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)  r_addr <= '0;
    else if (i_load) r_addr <= i_load_val;
    else if (i_en)   r_addr <= r_addr + ADDR_W'(1);
  end

  assign o_addr = r_addr;
endmodule

// File: rtl/ram_copy_engine.sv
// Bulk copy / fill master for RAM16K: drives address, data and load while busy.
`timescale 1ns/1ps
module ram_copy_engine
  import ram_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_fill_mode,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [ADDR_W-1:0] i_length,
  input  logic [DATA_W-1:0] i_fill_value,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_in,
  output logic              o_ram_load,
  input  logic [DATA_W-1:0] i_ram_out
);
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_count;
  logic              r_fill;
  logic              r_busy, r_done, r_load;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_accept;
  logic              w_src_en, w_dst_en;
  logic [ADDR_W-1:0] w_src, w_dst;

  assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_src_en = (r_state == ST_READ)  && !i_abort;
  assign w_dst_en = (r_state == ST_WRITE) && !i_abort;

  ram_addr_counter #(.ADDR_W(ADDR_W)) u_src_cnt (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_load     (w_accept),
    .i_load_val (i_src_addr),
    .i_en       (w_src_en),
    .o_addr     (w_src)
  );

  ram_addr_counter #(.ADDR_W(ADDR_W)) u_dst_cnt (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_load     (w_accept),
    .i_load_val (i_dst_addr),
    .i_en       (w_dst_en),
    .o_addr     (w_dst)
  );

  // Outputs are registered, so each transition preloads the address/data
  // the next state must present; r_data doubles as the copy data register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_fill  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_load  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_count <= i_length;
            r_fill  <= i_fill_mode;
            if (i_length == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (i_fill_mode) begin
              r_state <= ST_WRITE;
              r_busy  <= 1'b1;
              r_addr  <= i_dst_addr;
              r_data  <= i_fill_value;
              r_load  <= 1'b1;
            end else begin
              r_state <= ST_READ;
              r_busy  <= 1'b1;
              r_addr  <= i_src_addr;
              r_load  <= 1'b0;
            end
          end
        end
        ST_READ: begin
          r_state <= ST_WRITE;
          r_data  <= i_ram_out;
          r_addr  <= w_dst;
          r_load  <= 1'b1;
        end
        ST_WRITE: begin
          r_count <= r_count - ADDR_W'(1);
          if (r_count == ADDR_W'(1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_load  <= 1'b0;
          end else if (r_fill) begin
            r_addr  <= w_dst + ADDR_W'(1);
          end else begin
            r_state <= ST_READ;
            r_addr  <= w_src;
            r_load  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_ram_load    = r_load;
  assign o_ram_address = r_addr;
  assign o_ram_in      = r_data;
endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench: ram_copy_engine driving a behavioural 16K x 16 RAM.
`timescale 1ns/1ps
module tb_ram_copy_engine;
  import ram_copy_engine_pkg::*;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam logic [DW-1:0] BLANK = 16'hBEEF;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, fill_mode = 1'b0, abort = 1'b0;
  logic [AW-1:0] src = '0, dst = '0, len = '0;
  logic [DW-1:0] fval = '0;
  wire           busy, done, ram_load;
  wire  [AW-1:0] ram_address;
  wire  [DW-1:0] ram_in, ram_out;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0, init_mem = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int            load_cnt = 0, done_cnt = 0;
  int            checks = 0, failures = 0;

  always #1 clk = ~clk;

  ram_copy_engine dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_fill_mode(fill_mode),
    .i_src_addr(src), .i_dst_addr(dst), .i_length(len), .i_fill_value(fval),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_ram_address(ram_address),
    .o_ram_in(ram_in), .o_ram_load(ram_load), .i_ram_out(ram_out)
  );

  assign ram_out = mem[ram_address];

  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < (1<<AW); i++) mem[i] <= BLANK;
    else if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_load) mem[ram_address] <= ram_in;
    if (ram_load) load_cnt <= load_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  // lat = number of edges from the start edge (1) to the edge that raises done
  task automatic run_job(input logic f, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] v,
                         output int lat, output logic busy1, output int loads);
    int l0;
    l0 = load_cnt;
    fill_mode = f; src = s; dst = d; len = l; fval = v; start = 1'b1;
    lat = -1; busy1 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 1) begin start = 1'b0; busy1 = busy; end
      if (done) begin lat = k; break; end
    end
    loads = load_cnt - l0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", ram_load); end
    checks++; if (ram_address !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", ram_address); end
    checks++; if (ram_in !== '0) begin failures++; $display("FAIL reset_in got=%h exp=0", ram_in); end
    init_mem = 1'b1;
    tick();
    init_mem = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    int lat, loads; logic b1;
    run_job(1'b1, '0, 14'd100, 14'd4, 16'h00AA, lat, b1, loads);
    checks++; if (lat != 5) begin failures++; $display("FAIL fill_latency got=%0d exp=5", lat); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL fill_busy got=%b exp=1", b1); end
    checks++; if (loads != 4) begin failures++; $display("FAIL fill_loads got=%0d exp=4", loads); end
    for (int i = 100; i < 104; i++) begin
      checks++; if (mem[i] !== 16'h00AA) begin failures++; $display("FAIL fill_mem[%0d] got=%h exp=00aa", i, mem[i]); end
    end
    checks++; if (mem[104] !== BLANK) begin failures++; $display("FAIL fill_mem[104] got=%h exp=beef", mem[104]); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL fill_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_copy();
    int lat, loads; logic b1;
    poke(14'd10, 16'd1); poke(14'd11, 16'd2); poke(14'd12, 16'd3);
    run_job(1'b0, 14'd10, 14'd200, 14'd3, '0, lat, b1, loads);
    checks++; if (lat != 7) begin failures++; $display("FAIL copy_latency got=%0d exp=7", lat); end
    checks++; if (loads != 3) begin failures++; $display("FAIL copy_loads got=%0d exp=3", loads); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[200+i] !== DW'(i+1)) begin failures++; $display("FAIL copy_mem[%0d] got=%h exp=%0d", 200+i, mem[200+i], i+1); end
    end
    checks++; if (mem[203] !== BLANK) begin failures++; $display("FAIL copy_mem[203] got=%h exp=beef", mem[203]); end
  endtask

  task automatic test_wrap();
    int lat, loads; logic b1;
    run_job(1'b1, '0, 14'd16382, 14'd3, 16'd7, lat, b1, loads);
    checks++; if (lat != 4) begin failures++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    checks++; if (mem[16382] !== 16'd7) begin failures++; $display("FAIL wrap_mem[16382] got=%h exp=7", mem[16382]); end
    checks++; if (mem[16383] !== 16'd7) begin failures++; $display("FAIL wrap_mem[16383] got=%h exp=7", mem[16383]); end
    checks++; if (mem[0] !== 16'd7) begin failures++; $display("FAIL wrap_mem[0] got=%h exp=7", mem[0]); end
    checks++; if (mem[1] !== BLANK) begin failures++; $display("FAIL wrap_mem[1] got=%h exp=beef", mem[1]); end
    checks++; if (mem[16381] !== BLANK) begin failures++; $display("FAIL wrap_mem[16381] got=%h exp=beef", mem[16381]); end
  endtask

  task automatic test_zero_and_ignored();
    int lat, loads; logic b1;
    run_job(1'b1, '0, 14'd500, '0, 16'h0005, lat, b1, loads);
    checks++; if (lat != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (loads != 0) begin failures++; $display("FAIL zero_loads got=%0d exp=0", loads); end
    checks++; if (b1 !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", b1); end
    checks++; if (mem[500] !== BLANK) begin failures++; $display("FAIL zero_mem[500] got=%h exp=beef", mem[500]); end
    // second start mid-job with different parameters must be dropped
    fill_mode = 1'b1; dst = 14'd600; len = 14'd3; fval = 16'h1111; start = 1'b1; lat = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 2) begin start = 1'b1; dst = 14'd700; len = 14'd1; fval = 16'h2222; end
      if (k == 3) start = 1'b0;
      if (done) begin lat = k; break; end
    end
    tick();
    checks++; if (lat != 4) begin failures++; $display("FAIL ignored_latency got=%0d exp=4", lat); end
    for (int i = 600; i < 603; i++) begin
      checks++; if (mem[i] !== 16'h1111) begin failures++; $display("FAIL ignored_mem[%0d] got=%h exp=1111", i, mem[i]); end
    end
    checks++; if (mem[603] !== BLANK) begin failures++; $display("FAIL ignored_mem[603] got=%h exp=beef", mem[603]); end
    checks++; if (mem[700] !== BLANK) begin failures++; $display("FAIL ignored_mem[700] got=%h exp=beef", mem[700]); end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    fill_mode = 1'b1; dst = 14'd50; len = 14'd10; fval = 16'h0055; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 3) abort = 1'b1;
      if (k == 4) begin
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL abort_load got=%b exp=0", ram_load); end
      end
    end
    repeat (12) tick();
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL abort_no_done got=%0d exp=%0d", done_cnt, d0); end
    for (int i = 50; i < 60; i++) begin
      checks++;
      if (mem[i] !== ((i < 53) ? 16'h0055 : BLANK)) begin
        failures++; $display("FAIL abort_mem[%0d] got=%h exp=%h", i, mem[i], (i < 53) ? 16'h0055 : BLANK);
      end
    end
  endtask

  task automatic test_overlap();
    int lat, loads; logic b1;
    poke(14'd400, 16'h00A1); poke(14'd401, 16'h00B2); poke(14'd402, 16'h00C3);
    run_job(1'b0, 14'd400, 14'd401, 14'd2, '0, lat, b1, loads);
    checks++; if (lat != 5) begin failures++; $display("FAIL overlap_latency got=%0d exp=5", lat); end
    checks++; if (mem[401] !== 16'h00A1) begin failures++; $display("FAIL overlap_mem[401] got=%h exp=00a1", mem[401]); end
    checks++; if (mem[402] !== 16'h00A1) begin failures++; $display("FAIL overlap_mem[402] got=%h exp=00a1", mem[402]); end
  endtask

  task automatic test_reset_midcopy();
    int lat, loads; logic b1;
    poke(14'd20, 16'h0011); poke(14'd21, 16'h0022);
    fill_mode = 1'b0; src = 14'd20; dst = 14'd300; len = 14'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (ram_load !== 1'b1) begin failures++; $display("FAIL midcopy_in_write got=%b exp=1", ram_load); end
    #0.3 rst_n = 1'b0;
    #0.1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", busy); end
    checks++; if (ram_load !== 1'b0) begin failures++; $display("FAIL async_load got=%b exp=0", ram_load); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (mem[300] !== BLANK) begin failures++; $display("FAIL async_mem[300] got=%h exp=beef", mem[300]); end
    run_job(1'b0, 14'd20, 14'd310, 14'd2, '0, lat, b1, loads);
    checks++; if (lat != 5) begin failures++; $display("FAIL post_reset_latency got=%0d exp=5", lat); end
    checks++; if (mem[310] !== 16'h0011) begin failures++; $display("FAIL post_reset_mem[310] got=%h exp=0011", mem[310]); end
    checks++; if (mem[311] !== 16'h0022) begin failures++; $display("FAIL post_reset_mem[311] got=%h exp=0022", mem[311]); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_zero_and_ignored();
    test_abort();
    test_overlap();
    test_reset_midcopy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
